exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_seq_pkg.sv | 26 ++
 rtl/alu_shift.sv | 57 +++++
 rtl/exec_sequencer.sv | 137 +++++++++++++
 tb/tb_exec_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_seq_pkg.sv
// Shared types for the exec_sequencer: FSM states, ALU op codes and B-operand shift codes.
package exec_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReadA,
    StReadB,
    StExec,
    StWb
  } state_e;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpAnd = 2'b10,
    OpMvn = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ShNone = 2'b00,
    ShLsl1 = 2'b01,
    ShLsr1 = 2'b10,
    ShAsr1 = 2'b11
  } shift_e;

endpackage

// File: rtl/alu_shift.sv
// Combinational B-operand shifter and ALU producing the result and {V,N,Z} flags.
// Overflow detection is built only when EXEC_SEQ_OVF_EN is defined; otherwise V is tied to 0.
module alu_shift
  import exec_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  op_e               op_i,
  input  shift_e            shift_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] c_o,
  output logic [2:0]        flags_o
);

  localparam int unsigned Msb = DATA_W - 1;

  logic [DATA_W-1:0] bsh;
  logic              v;

  always_comb begin
    bsh = b_i;
    case (shift_i)
      ShLsl1:  bsh = {b_i[DATA_W-2:0], 1'b0};
      ShLsr1:  bsh = {1'b0, b_i[DATA_W-1:1]};
      ShAsr1:  bsh = {b_i[DATA_W-1], b_i[DATA_W-1:1]};
      default: bsh = b_i;
    endcase
  end

  always_comb begin
    c_o = '0;
    case (op_i)
      OpAdd:   c_o = a_i + bsh;
      OpSub:   c_o = a_i - bsh;
      OpAnd:   c_o = a_i & bsh;
      default: c_o = ~bsh;
    endcase
  end

`ifdef EXEC_SEQ_OVF_EN
  // Signed overflow: result sign differs from A where the operand signs make that impossible.
  always_comb begin
    v = 1'b0;
    case (op_i)
      OpAdd:   v = (a_i[Msb] == bsh[Msb]) && (c_o[Msb] != a_i[Msb]);
      OpSub:   v = (a_i[Msb] != bsh[Msb]) && (c_o[Msb] != a_i[Msb]);
      default: v = 1'b0;
    endcase
  end
`else
  assign v = 1'b0;
`endif

  assign flags_o = {v, c_o[Msb], (c_o == '0)};

endmodule

// File: rtl/exec_sequencer.sv
// Five-state sequencer executing one register-file ALU instruction per start request.
// Optional overflow flag enabled by the EXEC_SEQ_OVF_EN macro (see alu_shift).
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RNUM_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [1:0]        shift,
  input  logic [RNUM_W-1:0] rn,
  input  logic [RNUM_W-1:0] rm,
  input  logic [RNUM_W-1:0] rd,
  input  logic              wb_en,
  output logic [RNUM_W-1:0] readnum,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [RNUM_W-1:0] writenum,
  output logic              write,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              done,
  output logic [2:0]        status
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  shift_e            shift_q, shift_d;
  logic [RNUM_W-1:0] rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
  logic              wb_en_q, wb_en_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0]        status_q, status_d;

  logic [DATA_W-1:0] alu_c;
  logic [2:0]        alu_flags;

  alu_shift #(
    .DATA_W(DATA_W)
  ) u_alu_shift (
    .op_i   (op_q),
    .shift_i(shift_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .c_o    (alu_c),
    .flags_o(alu_flags)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    shift_d  = shift_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    rd_d     = rd_q;
    wb_en_d  = wb_en_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    status_d = status_q;
    busy     = 1'b1;
    done     = 1'b0;
    write    = 1'b0;
    readnum  = '0;
    writenum = '0;
    rf_wdata = '0;
    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          op_d    = op_e'(op);
          shift_d = shift_e'(shift);
          rn_d    = rn;
          rm_d    = rm;
          rd_d    = rd;
          wb_en_d = wb_en;
          state_d = StReadA;
        end
      end
      StReadA: begin
        readnum = rn_q;
        a_d     = rf_rdata;
        state_d = StReadB;
      end
      StReadB: begin
        readnum = rm_q;
        b_d     = rf_rdata;
        state_d = StExec;
      end
      StExec: begin
        c_d      = alu_c;
        status_d = alu_flags;
        state_d  = StWb;
      end
      StWb: begin
        done     = 1'b1;
        write    = wb_en_q;
        writenum = rd_q;
        rf_wdata = c_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      shift_q  <= ShNone;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      wb_en_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      shift_q  <= shift_d;
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      rd_q     <= rd_d;
      wb_en_q  <= wb_en_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      status_q <= status_d;
    end
  end

  assign status = status_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed vectors, random instructions against an
// arithmetic reference model, mid-WB reset and held-start throughput sequences.
module tb_exec_sequencer;

`ifdef EXEC_SEQ_OVF_EN
  localparam bit Ovf = 1'b1;
`else
  localparam bit Ovf = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op, shift;
  logic [2:0]  rn, rm, rd;
  logic        wb_en;
  logic [2:0]  readnum, writenum;
  logic [15:0] rf_rdata, rf_wdata;
  logic        write, busy, done;
  logic [2:0]  status;

  logic [15:0] rf     [8];
  logic [15:0] exp_rf [8];
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exec_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .shift   (shift),
    .rn      (rn),
    .rm      (rm),
    .rd      (rd),
    .wb_en   (wb_en),
    .readnum (readnum),
    .rf_rdata(rf_rdata),
    .writenum(writenum),
    .write   (write),
    .rf_wdata(rf_wdata),
    .busy    (busy),
    .done    (done),
    .status  (status)
  );

  // Register file environment; ld_* preloads it while the sequencer is idle.
  assign rf_rdata = rf[readnum];
  always @(posedge clk) begin
    if (write) rf[writenum] <= rf_wdata;
    else if (ld_en) rf[ld_addr] <= ld_data;
  end

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sh;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [2:0]  rd;
    logic        wb;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_c;
    logic [2:0]  exp_st;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: {V,N,Z,C} from plain integer arithmetic on 16-bit words.
  function automatic logic [18:0] model(input int opc, input int sh, input int a, input int b);
    int bs, r, sa, sb, sr;
    logic v;
    case (sh)
      0:       bs = b;
      1:       bs = (b * 2) % 65536;
      2:       bs = b / 2;
      default: bs = b / 2 + ((b >= 32768) ? 32768 : 0);
    endcase
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (bs >= 32768) ? bs - 65536 : bs;
    v = 1'b0;
    case (opc)
      0: begin sr = sa + sb; r = (a + bs) % 65536; v = (sr > 32767) || (sr < -32768); end
      1: begin sr = sa - sb; r = (a - bs + 65536) % 65536; v = (sr > 32767) || (sr < -32768); end
      2: r = a & bs;
      default: r = 65535 - bs;
    endcase
    if (!Ovf) v = 1'b0;
    return {v, (r >= 32768), (r == 0), 16'(r)};
  endfunction

  function automatic logic [127:0] flat_rf(input logic sel_dut);
    logic [127:0] f;
    for (int i = 0; i < 8; i++) f[i*16 +: 16] = sel_dut ? rf[i] : exp_rf[i];
    return f;
  endfunction

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
    exp_rf[a] = d;
  endtask

  task automatic do_instr(input logic [1:0] op_v, input logic [1:0] sh_v, input logic [2:0] rn_v,
                          input logic [2:0] rm_v, input logic [2:0] rd_v, input logic wb_v,
                          input logic [15:0] exp_c, input logic [2:0] exp_st, input string nm);
    logic [24:0] obs, expv;
    @(negedge clk);
    start = 1'b1; op = op_v; shift = sh_v; rn = rn_v; rm = rm_v; rd = rd_v; wb_en = wb_v;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0; op = 2'($urandom); rn = 3'($urandom); rd = 3'($urandom);
      end
      obs = {busy, done, write, readnum, writenum, rf_wdata};
      case (k)
        0:       expv = {1'b1, 1'b0, 1'b0, rn_v, 3'd0, 16'h0};
        1:       expv = {1'b1, 1'b0, 1'b0, rm_v, 3'd0, 16'h0};
        2:       expv = {1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0};
        3:       expv = {1'b1, 1'b1, wb_v, 3'd0, rd_v, exp_c};
        default: expv = 25'd0;
      endcase
      check($sformatf("%s_cyc%0d", nm, k), 128'(obs), 128'(expv));
    end
    if (wb_v) exp_rf[rd_v] = exp_c;
    check({nm, "_status"}, 128'(status), 128'(exp_st));
    check({nm, "_rf"}, flat_rf(1'b1), flat_rf(1'b0));
  endtask

  initial begin
    logic [18:0] m;
    logic [2:0]  r_rn, r_rm, r_rd;
    logic [1:0]  r_op, r_sh;
    logic        r_wb;
    int          ndone, first, gap, n;

    reset_n = 1'b0; start = 1'b0; op = 2'd0; shift = 2'd0; rn = 3'd0; rm = 3'd0; rd = 3'd0;
    wb_en = 1'b0; ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'h0;
    #3;
    check("reset_outs", 128'({busy, done, write, readnum, writenum, rf_wdata, status}), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) load(3'(i), 16'h0);

    vecs[0] = '{2'd0, 2'd0, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0005, 16'h0003, 16'h0008, 3'b000};
    vecs[1] = '{2'd1, 2'd0, 3'd1, 3'd2, 3'd4, 1'b0, 16'h1234, 16'h1234, 16'h0000, 3'b001};
    vecs[2] = '{2'd0, 2'd0, 3'd1, 3'd2, 3'd1, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, {Ovf, 2'b10}};
    vecs[3] = '{2'd3, 2'd3, 3'd1, 3'd2, 3'd5, 1'b1, 16'h0000, 16'h8002, 16'h3FFE, 3'b000};
    vecs[4] = '{2'd3, 2'd2, 3'd1, 3'd2, 3'd5, 1'b1, 16'h0000, 16'h8002, 16'hBFFE, 3'b010};
    for (int i = 0; i < 5; i++) begin
      load(vecs[i].rn, vecs[i].a);
      load(vecs[i].rm, vecs[i].b);
      do_instr(vecs[i].op, vecs[i].sh, vecs[i].rn, vecs[i].rm, vecs[i].rd, vecs[i].wb,
               vecs[i].exp_c, vecs[i].exp_st, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) load(3'(i), 16'($urandom));
    for (int t = 0; t < 40; t++) begin
      r_op = 2'($urandom); r_sh = 2'($urandom); r_rn = 3'($urandom); r_rm = 3'($urandom);
      r_rd = 3'($urandom); r_wb = ($urandom_range(0, 3) != 0);
      m = model(int'(r_op), int'(r_sh), int'(exp_rf[r_rn]), int'(exp_rf[r_rm]));
      do_instr(r_op, r_sh, r_rn, r_rm, r_rd, r_wb, m[15:0], m[18:16], $sformatf("rnd%0d", t));
    end

    // Reset during WB must abort the write.
    @(negedge clk);
    start = 1'b1; op = 2'd0; shift = 2'd0; rn = 3'd1; rm = 3'd2; rd = 3'd6; wb_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midwb_pre_write", 128'(write), 128'd1);
    #1 reset_n = 1'b0;
    #1 check("midwb_reset_outs",
             128'({busy, done, write, readnum, writenum, rf_wdata, status}), 128'd0);
    @(negedge clk);
    check("midwb_rf_unchanged", 128'(rf[6]), 128'(exp_rf[6]));
    @(posedge clk);
    #2 reset_n = 1'b1;
    m = model(0, 1, int'(exp_rf[3]), int'(exp_rf[4]));
    do_instr(2'd0, 2'd1, 3'd3, 3'd4, 3'd6, 1'b1, m[15:0], m[18:16], "post_reset");

    // Start held high: accepts at edges 0, 5, 10.
    m = model(1, 1, int'(exp_rf[1]), int'(exp_rf[2]));
    @(negedge clk);
    start = 1'b1; op = 2'd1; shift = 2'd1; rn = 3'd1; rm = 3'd2; rd = 3'd7; wb_en = 1'b1;
    ndone = 0; first = -1; gap = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (ndone == 1) gap = k - first;
        if (ndone == 0) first = k;
        ndone++;
      end
    end
    start = 1'b0;
    check("b2b_count", 128'(ndone), 128'd2);
    check("b2b_first", 128'(first), 128'd3);
    check("b2b_gap", 128'(gap), 128'd5);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_drain", 128'(busy), 128'd0);
    exp_rf[7] = m[15:0];
    check("b2b_status", 128'(status), 128'(m[18:16]));
    check("b2b_rf", flat_rf(1'b1), flat_rf(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
